// File: rtl/ser_bitstream.sv
// ser_bitstream
// Parallel-to-serial front end for the serial pattern detector. It accepts
// W-bit words on a valid/ready handshake and shifts them out one bit per
// clock. A one-word holding buffer lets consecutive words stream with no idle
// cycle between them. When no bit is in flight, op sits at IDLE_LVL.
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous reset, active low
//   din      parallel word to serialize
//   din_vld  din is valid
//   din_rdy  a word can be accepted this cycle
//   op       serial bit out (IDLE_LVL when op_vld = 0)
//   op_vld   op carries a data bit
//   sof      first bit of a word
//   busy     word in shift register or holding buffer
module ser_bitstream #(
   parameter int unsigned W         = 8,
   parameter bit          LSB_FIRST = 1'b0,
   parameter bit          IDLE_LVL  = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   input  logic         din_vld,
   output logic         din_rdy,
   output logic         op,
   output logic         op_vld,
   output logic         sof,
   output logic         busy
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   sreg_q, sreg_d;
   logic [W-1:0]   hold_q, hold_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           hold_full_q, hold_full_d;

   logic           xfer;
   logic           last;
   logic           out_bit;
   logic [W-1:0]   sreg_shift;

   // Ready is low during reset and whenever the holding buffer is occupied,
   // which makes a transfer and a hold-drain in the same cycle impossible.
   assign din_rdy    = rst_n & ~hold_full_q;
   assign xfer       = din_vld & din_rdy;
   assign last       = (cnt_q == CW'(W - 1));
   assign out_bit    = LSB_FIRST ? sreg_q[0] : sreg_q[W-1];
   assign sreg_shift = LSB_FIRST ? {1'b0, sreg_q[W-1:1]} : {sreg_q[W-2:0], 1'b0};

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (xfer) state_d = SHIFT;
         SHIFT: if (last && !hold_full_q && !xfer) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sreg_q      <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
      end else begin
         sreg_q      <= sreg_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
      end
   end

   // datapath next-state
   always_comb begin
      sreg_d      = sreg_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      hold_full_d = hold_full_q;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               sreg_d = din;
               cnt_d  = '0;
            end
         end
         SHIFT: begin
            if (last) begin
               // Word boundary: the held word has priority; otherwise a word
               // arriving right now is loaded directly so no gap appears.
               cnt_d  = '0;
               sreg_d = sreg_shift;
               if (hold_full_q) begin
                  sreg_d      = hold_q;
                  hold_full_d = 1'b0;
               end else if (xfer) begin
                  sreg_d = din;
               end
            end else begin
               sreg_d = sreg_shift;
               cnt_d  = cnt_q + 1'b1;
               if (xfer) begin
                  hold_d      = din;
                  hold_full_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // outputs come from registered state only
   always_comb begin
      op_vld = (state_q == SHIFT);
      op     = op_vld ? out_bit : IDLE_LVL;
      sof    = op_vld & (cnt_q == '0);
      busy   = op_vld | hold_full_q;
   end

endmodule

// File: tb/tb_ser_bitstream.sv
module tb_ser_bitstream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dut0: W=8, MSB first, idle low
   logic       rst0, vld0, rdy0, op0, ov0, sof0, busy0;
   logic [7:0] din0;
   // dut1: W=8, LSB first, idle high
   logic       rst1, vld1, rdy1, op1, ov1, sof1, busy1;
   logic [7:0] din1;

   ser_bitstream #(.W(8), .LSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut0 (
      .clk(clk), .rst_n(rst0), .din(din0), .din_vld(vld0), .din_rdy(rdy0),
      .op(op0), .op_vld(ov0), .sof(sof0), .busy(busy0));

   ser_bitstream #(.W(8), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut1 (
      .clk(clk), .rst_n(rst1), .din(din1), .din_vld(vld1), .din_rdy(rdy1),
      .op(op1), .op_vld(ov1), .sof(sof1), .busy(busy1));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // bit i (0 = first transmitted) of an 8-bit word
   function automatic logic bit_of(input logic [7:0] w, input int i, input bit lsb);
      return lsb ? w[i] : w[7-i];
   endfunction

   logic [7:0] words[3];
   logic [7:0] bq[$];
   logic [7:0] pend, rx, expw;
   logic       lsb_exp[8];
   int         sent, rcv, bitcnt, widx;

   initial begin
      rst0 = 1'b0; vld0 = 1'b0; din0 = '0;
      rst1 = 1'b0; vld1 = 1'b0; din1 = '0;
      tick(); tick();

      // ---------------- reset state ----------------
      chk("rst_op", op0, 0);
      chk("rst_op_vld", ov0, 0);
      chk("rst_sof", sof0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_din_rdy", rdy0, 0);
      chk("rst_op_idle_hi", op1, 1);

      // ---------------- single word 0xB4 ----------------
      rst0 = 1'b1; vld0 = 1'b1; din0 = 8'hB4;
      #1 chk("single_rdy", rdy0, 1);
      tick();
      vld0 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("single_op", op0, bit_of(8'hB4, i, 1'b0));
         chk("single_vld", ov0, 1);
         chk("single_sof", sof0, (i == 0));
         tick();
      end
      chk("single_end_vld", ov0, 0);
      chk("single_end_op", op0, 0);
      chk("single_end_busy", busy0, 0);
      tick();

      // ---------------- back-to-back FF, 00, A5 ----------------
      words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'hA5;
      widx = 0;
      for (int c = 0; c < 27; c++) begin
         vld0 = (widx < 3);
         din0 = (widx < 3) ? words[widx] : 8'h00;
         chk("b2b_rdy", rdy0, !((c >= 2 && c <= 8) || (c >= 10 && c <= 16)));
         if (c >= 1 && c <= 24) begin
            chk("b2b_vld", ov0, 1);
            chk("b2b_op", op0, bit_of(words[(c-1)/8], (c-1)%8, 1'b0));
            chk("b2b_sof", sof0, ((c-1)%8 == 0));
         end else begin
            chk("b2b_idle_vld", ov0, 0);
         end
         if (vld0 && rdy0) widx++;
         tick();
      end
      vld0 = 1'b0;
      chk("b2b_all_taken", widx, 3);
      tick();

      // ---------------- direct load at cnt == 7 ----------------
      words[0] = 8'h5A; words[1] = 8'hC3;
      for (int c = 0; c < 18; c++) begin
         vld0 = (c == 0) || (c == 8);
         din0 = (c == 0) ? words[0] : words[1];
         if (c == 8) begin
            chk("direct_rdy", rdy0, 1);
            chk("direct_busy", busy0, 1);
         end
         if (c >= 1 && c <= 16) begin
            chk("direct_vld", ov0, 1);
            chk("direct_op", op0, bit_of(words[(c-1)/8], (c-1)%8, 1'b0));
            chk("direct_sof", sof0, ((c-1)%8 == 0));
         end else begin
            chk("direct_idle_vld", ov0, 0);
         end
         tick();
      end
      vld0 = 1'b0;

      // ---------------- reset mid-word with a held word ----------------
      vld0 = 1'b1; din0 = 8'h3C;
      tick();
      din0 = 8'h99;
      tick();
      vld0 = 1'b0;
      chk("rstmid_held", rdy0, 0);
      tick(); tick();
      chk("rstmid_busy_before", busy0, 1);
      rst0 = 1'b0;
      tick();
      chk("rstmid_vld", ov0, 0);
      chk("rstmid_busy", busy0, 0);
      chk("rstmid_op", op0, 0);
      chk("rstmid_rdy_low", rdy0, 0);
      tick();
      chk("rstmid_rdy_low2", rdy0, 0);
      rst0 = 1'b1;
      #1 chk("rstmid_rdy_release", rdy0, 1);
      tick();
      for (int c = 0; c < 12; c++) begin
         chk("rstmid_no_resume", {busy0, ov0}, 2'b00);
         tick();
      end

      // ---------------- LSB first, idle high: 0x0D ----------------
      lsb_exp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      rst1 = 1'b1;
      tick();
      chk("lsb_pre_idle_op", op1, 1);
      chk("lsb_pre_idle_vld", ov1, 0);
      vld1 = 1'b1; din1 = 8'h0D;
      tick();
      vld1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("lsb_op", op1, lsb_exp[i]);
         chk("lsb_sof", sof1, (i == 0));
         chk("lsb_vld", ov1, 1);
         tick();
      end
      chk("lsb_post_idle_op", op1, 1);
      chk("lsb_post_idle_vld", ov1, 0);
      tick();
      chk("lsb_post_idle_op2", op1, 1);

      // ---------------- randomized backpressure, 200 words ----------------
      pend = 8'($urandom); sent = 0; rcv = 0; bitcnt = 0; rx = '0;
      for (int c = 0; c < 20000 && rcv < 200; c++) begin
         vld0 = (sent < 200) && ($urandom_range(0, 1) == 1);
         din0 = pend;
         if (ov0) begin
            chk("rnd_sof", sof0, (bitcnt == 0));
            rx = {rx[6:0], op0};
            bitcnt++;
            if (bitcnt == 8) begin
               chk("rnd_underflow", (bq.size() > 0), 1);
               expw = (bq.size() > 0) ? bq.pop_front() : 8'h00;
               chk("rnd_word", rx, expw);
               rcv++;
               bitcnt = 0;
            end
         end else begin
            chk("rnd_idle_op", op0, 0);
            chk("rnd_gap", bitcnt, 0);
         end
         if (vld0 && rdy0) begin
            bq.push_back(pend);
            sent++;
            pend = 8'($urandom);
         end
         tick();
      end
      vld0 = 1'b0;
      chk("rnd_words_rx", rcv, 200);
      chk("rnd_q_empty", bq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ser_bitstream.md
Name: ser_bitstream

Overview:
- Parallel-to-serial front end that feeds the serial pattern-detector stage.
- Accepts W-bit words on a valid/ready handshake and emits them one bit per clock on `op`, qualified by `op_vld`.
- Double-buffered: back-to-back words stream with zero idle cycles between them.
- Drives a programmable idle level when no word is in flight, so the detector downstream sees a defined input at all times.

Parameters:
- W, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = shift out MSB first, 1 = shift out LSB first.
- IDLE_LVL, 0, value driven on `op` whenever `op_vld` = 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- din  input  W  parallel word to serialize.
- din_vld  input  1  `din` is valid.
- din_rdy  output  1  block can accept a word this cycle.
- op  output  1  serial bit out; equals IDLE_LVL when `op_vld` = 0.
- op_vld  output  1  `op` carries a data bit this cycle.
- sof  output  1  high during the first bit of each word.
- busy  output  1  word in shift register or holding buffer.

Behaviour:
- Registers: state (IDLE/SHIFT), `sreg[W-1:0]`, `cnt` (clog2(W) bits), `hold[W-1:0]`, `hold_full`.
- Reset (`rst_n` low at a clk edge): state = IDLE, `cnt` = 0, `sreg` = 0, `hold_full` = 0.
  - While reset is asserted, `din_rdy` = 0.
  - Resulting outputs: `op` = IDLE_LVL, `op_vld` = 0, `sof` = 0, `busy` = 0.
  - Reset mid-word discards the in-flight word and the held word without emitting further bits; `op_vld` is 0 the cycle after the reset edge.
- Handshake: `din_rdy` = `rst_n` & !`hold_full` (combinational). Transfer occurs when `din_vld` & `din_rdy` at a clk edge. `din` must be stable only in the transfer cycle.
- IDLE:
  - On a transfer, load `sreg` = `din`, `cnt` = 0, go to SHIFT. First bit appears on `op` in the next cycle (latency 1).
  - `hold_full` is never 1 in IDLE.
- SHIFT:
  - `op` = `sreg[W-1]` (MSB-first) or `sreg[0]` (LSB_FIRST).
  - `op_vld` = 1; `sof` = (`cnt` == 0).
  - Each edge: shift `sreg` toward the output bit and increment `cnt`.
  - A transfer while `cnt` < W-1 writes `hold` and sets `hold_full`.
- Last bit (`cnt` == W-1) at a clk edge:
  - If `hold_full`: `sreg` = `hold`, `hold_full` = 0, `cnt` = 0, stay in SHIFT.
  - Else if a transfer occurs in this cycle: `sreg` = `din` directly, `cnt` = 0, stay in SHIFT.
  - Else: go to IDLE, `cnt` = 0.
- Simultaneous transfer and hold-drain is impossible, because `din_rdy` = 0 whenever `hold_full` = 1.
- `busy` = (state == SHIFT) | `hold_full`.
- `cnt` wraps only through the explicit reload to 0; it never counts past W-1.
- `op` and `op_vld` are derived from registered state only (no combinational path from `din`/`din_vld`). This keeps the downstream detector's Mealy output free of input-to-output paths through this block.

Test Plan (W=8, LSB_FIRST=0, IDLE_LVL=0 unless stated):
- Single word: release reset, one transfer of 0xB4 in cycle 0.
  - Cycles 1..8: `op` = 1,0,1,1,0,1,0,0, `op_vld` = 1, `sof` = 1 only in cycle 1.
  - Cycle 9: `op_vld` = 0, `op` = 0, `busy` = 0.
- Back-to-back: 0xFF then 0x00 then 0xA5, with `din_vld` held high.
  - 24 consecutive valid bits with no gap; `sof` in cycles 1, 9 and 17.
  - `din_rdy` is 0 from the cycle after the second word is held until the reload edge.
- Direct load at the boundary: second word presented exactly in the cycle with `cnt` == 7 and `hold` empty.
  - Its first bit follows the previous word's last bit with no gap, and `sof` = 1.
- Reset mid-operation: assert `rst_n` = 0 during bit 4 of 0x3C with a word held.
  - Next cycle: `op_vld` = 0, `busy` = 0, `din_rdy` = 0 while reset is low, and 1 after release.
  - Neither word resumes.
- LSB_FIRST=1, IDLE_LVL=1: word 0x0D.
  - Bits 1,0,1,1,0,0,0,0; `op` = 1 in the idle cycles before and after the word.
- Backpressure: `din_vld` toggling randomly for 200 words.
  - The serial stream reconstructs exactly the accepted words in order, with no bit dropped or duplicated.
